comparator_bist: RTL and testbench

//  On-chip exhaustive self-test engine for a WIDTH-bit magnitude comparator: drives every
//  (a,b) operand pair into the comparator under test and checks its eq/lt/gt flags.

---
 rtl/cmp_pkg.sv | 28 ++
 rtl/comparator_bist_if.sv | 29 ++
 rtl/cmp_vector_gen.sv | 29 ++
 rtl/comparator_bist.sv | 129 ++++++++++++
 tb/tb_comparator_bist.sv | 141 ++++++++++++++
 5 files changed

// File: rtl/cmp_pkg.sv
// Shared types and the golden comparator model for the comparator self-test engine.
package cmp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DONE   = 3'd4
    } bist_state_t;

    localparam logic [2:0] FLAG_EQ = 3'b100;
    localparam logic [2:0] FLAG_LT = 3'b010;
    localparam logic [2:0] FLAG_GT = 3'b001;

    // Operands arrive zero-extended so one function serves any operand width.
    function automatic logic [2:0] cmp_golden(input logic [31:0] a, input logic [31:0] b);
        logic [2:0] flags;
        if (a == b)
            flags = FLAG_EQ;
        else if (a < b)
            flags = FLAG_LT;
        else
            flags = FLAG_GT;
        return flags;
    endfunction

endpackage

// File: rtl/comparator_bist_if.sv
// Bus between the self-test engine (master) and the comparator/host side (slave).
interface comparator_bist_if #(
    parameter int WIDTH     = 4,
    parameter int ERR_CNT_W = 8
);
    logic                 start;
    logic [WIDTH-1:0]     dut_a;
    logic [WIDTH-1:0]     dut_b;
    logic                 dut_eq;
    logic                 dut_lt;
    logic                 dut_gt;
    logic                 busy;
    logic                 done;
    logic                 pass;
    logic [ERR_CNT_W-1:0] err_count;
    logic [WIDTH-1:0]     fail_a;
    logic [WIDTH-1:0]     fail_b;
    logic [2:0]           fail_flags;

    modport master (
        input  start, dut_eq, dut_lt, dut_gt,
        output dut_a, dut_b, busy, done, pass, err_count, fail_a, fail_b, fail_flags
    );

    modport slave (
        output start, dut_eq, dut_lt, dut_gt,
        input  dut_a, dut_b, busy, done, pass, err_count, fail_a, fail_b, fail_flags
    );
endinterface

// File: rtl/cmp_vector_gen.sv
// Sweep counter over all (a,b) operand pairs; a is the upper half so b varies fastest.
module cmp_vector_gen #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic             i_step,
    output logic [WIDTH-1:0] o_a,
    output logic [WIDTH-1:0] o_b,
    output logic             o_last
);
    logic [2*WIDTH-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (i_clear)
            r_cnt <= '0;
        else if (i_step)
            r_cnt <= r_cnt + 1'b1;
    end

    assign o_a = r_cnt[2*WIDTH-1:WIDTH];
    assign o_b = r_cnt[WIDTH-1:0];

    // Explicit all-ones match on both halves so the end of sweep never depends on wrap.
    assign o_last = (o_a == {WIDTH{1'b1}}) && (o_b == {WIDTH{1'b1}});
endmodule

// File: rtl/comparator_bist.sv
// Exhaustive self-test of a magnitude comparator: sweeps every operand pair, checks the
// eq/lt/gt flags against the golden model, counts errors and captures the first failure.
module comparator_bist
    import cmp_pkg::*;
#(
    parameter int WIDTH         = 4,
    parameter int SETTLE_CYCLES = 2,
    parameter int ERR_CNT_W     = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    comparator_bist_if.master        bus
);
    localparam int SCW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    bist_state_t          r_state;
    logic [SCW-1:0]       r_settle_cnt;
    logic [WIDTH-1:0]     r_dut_a;
    logic [WIDTH-1:0]     r_dut_b;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_pass;
    logic [ERR_CNT_W-1:0] r_err_count;
    logic [WIDTH-1:0]     r_fail_a;
    logic [WIDTH-1:0]     r_fail_b;
    logic [2:0]           r_fail_flags;

    logic [WIDTH-1:0]     w_vec_a;
    logic [WIDTH-1:0]     w_vec_b;
    logic                 w_last;
    logic                 w_start_ok;
    logic                 w_gen_step;
    logic [2:0]           w_obs;
    logic [2:0]           w_golden;
    logic                 w_mismatch;
    logic [ERR_CNT_W-1:0] w_err_next;

    assign w_start_ok = bus.start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_gen_step = (r_state == ST_CHECK) && !w_last;

    cmp_vector_gen #(
        .WIDTH (WIDTH)
    ) u_vector_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (w_start_ok),
        .i_step  (w_gen_step),
        .o_a     (w_vec_a),
        .o_b     (w_vec_b),
        .o_last  (w_last)
    );

    // Checking the registered operands keeps the golden value tied to what the comparator sees.
    assign w_obs      = {bus.dut_eq, bus.dut_lt, bus.dut_gt};
    assign w_golden   = cmp_golden(32'(r_dut_a), 32'(r_dut_b));
    assign w_mismatch = (r_state == ST_CHECK) && (w_obs != w_golden);
    assign w_err_next = (w_mismatch && !(&r_err_count)) ? r_err_count + 1'b1 : r_err_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_settle_cnt <= '0;
            r_dut_a      <= '0;
            r_dut_b      <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_err_count  <= '0;
            r_fail_a     <= '0;
            r_fail_b     <= '0;
            r_fail_flags <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_start_ok) begin
                        r_state      <= ST_LOAD;
                        r_busy       <= 1'b1;
                        r_done       <= 1'b0;
                        r_pass       <= 1'b0;
                        r_err_count  <= '0;
                        r_fail_a     <= '0;
                        r_fail_b     <= '0;
                        r_fail_flags <= '0;
                    end
                end
                ST_LOAD: begin
                    r_dut_a      <= w_vec_a;
                    r_dut_b      <= w_vec_b;
                    r_settle_cnt <= SCW'(SETTLE_CYCLES - 1);
                    r_state      <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (r_settle_cnt == '0)
                        r_state <= ST_CHECK;
                    else
                        r_settle_cnt <= r_settle_cnt - 1'b1;
                end
                ST_CHECK: begin
                    r_err_count <= w_err_next;
                    // A zero count means no mismatch yet this sweep; it never wraps back to zero.
                    if (w_mismatch && (r_err_count == '0)) begin
                        r_fail_a     <= r_dut_a;
                        r_fail_b     <= r_dut_b;
                        r_fail_flags <= w_obs;
                    end
                    if (w_last) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (w_err_next == '0);
                    end else begin
                        r_state <= ST_LOAD;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.dut_a      = r_dut_a;
    assign bus.dut_b      = r_dut_b;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.pass       = r_pass;
    assign bus.err_count  = r_err_count;
    assign bus.fail_a     = r_fail_a;
    assign bus.fail_b     = r_fail_b;
    assign bus.fail_flags = r_fail_flags;
endmodule

// File: tb/tb_comparator_bist.sv
// Drives two self-test engines (8-bit and 4-bit error counters) against a fault-injectable
// comparator model and checks their reports against a sweep computed in the bench.
module tb_comparator_bist;
    localparam int W = 4;
    localparam int N = 1 << W;

    logic     clk = 1'b0;
    logic     rst_n;
    logic     start;
    int       mode;
    logic [2:0] rnd_xor [N*N];
    int       n_tests = 0;
    int       n_fail  = 0;

    comparator_bist_if #(.WIDTH(W), .ERR_CNT_W(8)) bus8 ();
    comparator_bist_if #(.WIDTH(W), .ERR_CNT_W(4)) bus4 ();

    comparator_bist #(.WIDTH(W), .SETTLE_CYCLES(2), .ERR_CNT_W(8)) u_dut8 (
        .clk (clk), .rst_n (rst_n), .bus (bus8.master)
    );
    comparator_bist #(.WIDTH(W), .SETTLE_CYCLES(2), .ERR_CNT_W(4)) u_dut4 (
        .clk (clk), .rst_n (rst_n), .bus (bus4.master)
    );

    always #5 clk = ~clk;

    // Comparator under test: correct, gt stuck-at-0, lt/gt swapped, or random flag corruption.
    function automatic logic [2:0] faulty_cmp(input int a, input int b, input int m);
        logic [2:0] g;
        g = (a == b) ? 3'b100 : ((a < b) ? 3'b010 : 3'b001);
        case (m)
            1:       return {g[2], g[1], 1'b0};
            2:       return {g[2], g[0], g[1]};
            3:       return g ^ rnd_xor[a*N + b];
            default: return g;
        endcase
    endfunction

    assign bus8.start = start;
    assign bus4.start = start;
    always_comb {bus8.dut_eq, bus8.dut_lt, bus8.dut_gt} = faulty_cmp(int'(bus8.dut_a), int'(bus8.dut_b), mode);
    always_comb {bus4.dut_eq, bus4.dut_lt, bus4.dut_gt} = faulty_cmp(int'(bus4.dut_a), int'(bus4.dut_b), mode);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_8"}, {bus8.busy, bus8.done, bus8.pass, bus8.err_count, bus8.fail_a,
                          bus8.fail_b, bus8.fail_flags, bus8.dut_a, bus8.dut_b}, 0);
        chk({tag, "_4"}, {bus4.busy, bus4.done, bus4.pass, bus4.err_count, bus4.fail_a,
                          bus4.fail_b, bus4.fail_flags, bus4.dut_a, bus4.dut_b}, 0);
    endtask

    // abort_at > 0: assert reset asynchronously after that many busy cycles and return.
    task automatic run_sweep(input int m, input bit restart, input int abort_at);
        int cycles, exp_err, exp_fa, exp_fb, exp_ff;
        logic [2:0] obs, gold;
        mode = m;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        chk("clr_err", 32'(bus8.err_count), 0);
        chk("clr_done", 32'(bus8.done), 0);
        chk("clr_fail", {bus8.fail_a, bus8.fail_b, bus8.fail_flags}, 0);
        cycles = 0;
        while (bus8.busy && cycles < 3000) begin
            cycles++;
            if (abort_at != 0 && cycles == abort_at) begin
                #2 rst_n = 1'b0;
                #1 chk_all_zero("abort_rst");
                @(negedge clk) rst_n = 1'b1;
                $display("[TB] sweep mode=%0d aborted by reset after %0d cycles", m, cycles);
                return;
            end
            start = restart && (cycles == 500);
            @(negedge clk);
        end
        start = 1'b0;

        exp_err = 0; exp_fa = 0; exp_fb = 0; exp_ff = 0;
        for (int a = 0; a < N; a++) begin
            for (int b = 0; b < N; b++) begin
                gold = (a == b) ? 3'b100 : ((a < b) ? 3'b010 : 3'b001);
                obs  = faulty_cmp(a, b, m);
                if (obs != gold) begin
                    if (exp_err == 0) begin
                        exp_fa = a; exp_fb = b; exp_ff = int'(obs);
                    end
                    exp_err++;
                end
            end
        end

        chk("busy_cycles", 32'(cycles), N*N*4);
        chk("done", 32'(bus8.done), 1);
        chk("err8", 32'(bus8.err_count), 32'((exp_err > 255) ? 255 : exp_err));
        chk("pass8", 32'(bus8.pass), 32'(exp_err == 0));
        chk("fail_a", 32'(bus8.fail_a), 32'(exp_fa));
        chk("fail_b", 32'(bus8.fail_b), 32'(exp_fb));
        chk("fail_flags", 32'(bus8.fail_flags), 32'(exp_ff));
        chk("hold_ab", {bus8.dut_a, bus8.dut_b}, 32'hFF);
        chk("err4", 32'(bus4.err_count), 32'((exp_err > 15) ? 15 : exp_err));
        chk("pass4", 32'(bus4.pass), 32'(exp_err == 0));
        chk("fail4", {bus4.fail_a, bus4.fail_b, bus4.fail_flags}, 32'((exp_fa << 7) | (exp_fb << 3) | exp_ff));
        $display("[TB] sweep mode=%0d restart=%0d busy=%0d err=%0d exp_err=%0d first=(%0d,%0d,%03b)",
                 m, restart, cycles, bus8.err_count, exp_err, exp_fa, exp_fb, exp_ff[2:0]);
    endtask

    initial begin
        for (int i = 0; i < N*N; i++) rnd_xor[i] = 3'b000;
        mode  = 0;
        start = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk_all_zero("idle");

        run_sweep(0, 1'b0, 0);
        run_sweep(1, 1'b0, 0);
        run_sweep(2, 1'b1, 0);
        run_sweep(0, 1'b0, 0);
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < N*N; i++)
                rnd_xor[i] = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            run_sweep(3, 1'b0, 0);
        end
        run_sweep(2, 1'b0, 300);
        repeat (2) @(negedge clk);
        chk_all_zero("post_abort");
        run_sweep(0, 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
